// File: rtl/ws2812_cfg_pkg.sv
// Shared WS2812 config register IDs, frame size and encoder state type.
// Used by both the host-side encoder and the config controller that drains the FIFO.
package ws2812_cfg_pkg;

  localparam logic [7:0] CFG_ID_LENGTH   = 8'h01;
  localparam logic [7:0] CFG_ID_SHIFT    = 8'h02;
  localparam logic [7:0] CFG_ID_DELAY    = 8'h03;
  localparam logic [7:0] CFG_ID_NUM_LEDS = 8'h04;
  localparam int         CFG_FRAME_BYTES = 3;
  localparam int         CFG_NUM_REGS    = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_ID,
    ST_SEND_MSB,
    ST_SEND_LSB,
    ST_NEXT
  } cfg_enc_state_e;

  function automatic logic cfg_id_valid(input logic [7:0] id);
    return (id >= CFG_ID_LENGTH) && (id <= CFG_ID_NUM_LEDS);
  endfunction

  function automatic logic [1:0] cfg_id_to_idx(input logic [7:0] id);
    logic [7:0] t;
    t = id - 8'd1;
    return t[1:0];
  endfunction

endpackage

// File: rtl/ws2812_config_encoder.sv
// Register-write requests -> 3-byte frames (ID, MSB, LSB); first byte the cycle after acceptance.
// f_full stalls the current byte in place; sync_all replays all four shadows as 12 bytes.
module ws2812_config_encoder
  import ws2812_cfg_pkg::*;
#(
  parameter int PHY_FIFO_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [7:0]                cmd_id,
  input  logic [15:0]               cmd_value,
  input  logic                      sync_all,
  input  logic                      f_full,
  output logic                      fifo_write_en,
  output logic [PHY_FIFO_WIDTH-1:0] fifo_write_data,
  output logic                      cmd_error,
  output logic                      busy,
  output logic [15:0]               bytes_written
);

  cfg_enc_state_e state_q, state_d;
  logic [7:0]     id_q, id_d;
  logic [15:0]    val_q, val_d;
  logic [1:0]     idx_q, idx_d;
  logic           replay_q, replay_d;
  logic           sync_pending_q, sync_pending_d;
  logic           cmd_error_q, cmd_error_d;
  logic [15:0]    bytes_q, bytes_d;
  logic [15:0]    shadow_q [CFG_NUM_REGS];
  logic           shadow_we;
  logic [1:0]     shadow_idx;
  logic           pend_eff;
  logic [7:0]     byte_out;
  logic           sending;

  assign sending = (state_q == ST_SEND_ID) || (state_q == ST_SEND_MSB) ||
                   (state_q == ST_SEND_LSB);
  assign fifo_write_en   = sending & ~f_full & ~reset;
  assign fifo_write_data = PHY_FIFO_WIDTH'(byte_out);
  // A same-cycle sync_all already counts as pending so it wins over cmd_valid.
  assign pend_eff        = sync_pending_q | sync_all;
  assign cmd_ready       = (state_q == ST_IDLE) & ~pend_eff & ~reset;
  assign cmd_error       = cmd_error_q;
  assign busy            = (state_q != ST_IDLE) | sync_pending_q;
  assign bytes_written   = bytes_q;

  always_comb begin
    byte_out = 8'h00;
    case (state_q)
      ST_SEND_ID:  byte_out = id_q;
      ST_SEND_MSB: byte_out = val_q[15:8];
      ST_SEND_LSB: byte_out = val_q[7:0];
      default:     byte_out = 8'h00;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    id_d           = id_q;
    val_d          = val_q;
    idx_d          = idx_q;
    replay_d       = replay_q;
    sync_pending_d = pend_eff;
    cmd_error_d    = 1'b0;
    shadow_we      = 1'b0;
    shadow_idx     = cfg_id_to_idx(cmd_id);
    bytes_d        = bytes_q + (fifo_write_en ? 16'd1 : 16'd0);
    case (state_q)
      ST_IDLE: begin
        if (pend_eff) begin
          sync_pending_d = 1'b0;
          replay_d       = 1'b1;
          idx_d          = 2'd0;
          id_d           = CFG_ID_LENGTH;
          val_d          = shadow_q[0];
          state_d        = ST_SEND_ID;
        end else if (cmd_valid) begin
          if (cfg_id_valid(cmd_id)) begin
            shadow_we = 1'b1;
            replay_d  = 1'b0;
            id_d      = cmd_id;
            val_d     = cmd_value;
            state_d   = ST_SEND_ID;
          end else begin
            cmd_error_d = 1'b1;
          end
        end
      end
      ST_SEND_ID:  if (fifo_write_en) state_d = ST_SEND_MSB;
      ST_SEND_MSB: if (fifo_write_en) state_d = ST_SEND_LSB;
      ST_SEND_LSB: if (fifo_write_en) state_d = ST_NEXT;
      ST_NEXT: begin
        if (replay_q && (idx_q != 2'd3)) begin
          idx_d   = idx_q + 2'd1;
          id_d    = 8'(idx_q) + 8'd2;
          val_d   = shadow_q[idx_d];
          state_d = ST_SEND_ID;
        end else begin
          replay_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      id_q           <= 8'h00;
      val_q          <= 16'h0000;
      idx_q          <= 2'd0;
      replay_q       <= 1'b0;
      sync_pending_q <= 1'b0;
      cmd_error_q    <= 1'b0;
      bytes_q        <= 16'h0000;
      for (int i = 0; i < CFG_NUM_REGS; i++) shadow_q[i] <= 16'h0000;
    end else begin
      state_q        <= state_d;
      id_q           <= id_d;
      val_q          <= val_d;
      idx_q          <= idx_d;
      replay_q       <= replay_d;
      sync_pending_q <= sync_pending_d;
      cmd_error_q    <= cmd_error_d;
      bytes_q        <= bytes_d;
      if (shadow_we) shadow_q[shadow_idx] <= cmd_value;
    end
  end

endmodule

// File: tb/tb_ws2812_config_encoder.sv
// Self-checking bench: byte scoreboard fed at stimulus time, table of commands, corner sequences.
module tb_ws2812_config_encoder;

  logic        clk = 1'b0;
  logic        reset, cmd_valid, sync_all, f_full;
  logic        cmd_ready, fifo_write_en, cmd_error, busy;
  logic [7:0]  cmd_id;
  logic [15:0] cmd_value, bytes_written;
  logic [7:0]  fifo_write_data;

  ws2812_config_encoder #(.PHY_FIFO_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_id(cmd_id), .cmd_value(cmd_value), .sync_all(sync_all), .f_full(f_full),
    .fifo_write_en(fifo_write_en), .fifo_write_data(fifo_write_data),
    .cmd_error(cmd_error), .busy(busy), .bytes_written(bytes_written)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  id;
    logic [15:0] val;
    logic        exp_err;
  } vec_t;

  int          total = 0;
  int          bad = 0;
  int          wr_seen = 0;
  logic [15:0] exp_bytes = 16'd0;
  logic [7:0]  exp_q[$];
  logic [15:0] sh[4];
  vec_t        vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && fifo_write_en) begin
      wr_seen++;
      if (exp_q.size() == 0) check("unexpected_write", 32'd1, 32'd0);
      else check("fifo_byte", {24'b0, fifo_write_data}, {24'b0, exp_q.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [7:0] id, input logic [15:0] val);
    exp_q.push_back(id);
    exp_q.push_back(val[15:8]);
    exp_q.push_back(val[7:0]);
    exp_bytes = exp_bytes + 16'd3;
  endtask

  task automatic push_replay();
    for (int r = 0; r < 4; r++) push_frame(8'(r + 1), sh[r]);
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send_cmd(input logic [7:0] id, input logic [15:0] val);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_id    = id;
    cmd_value = val;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("send_cmd_timeout", n < 200, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 400) begin
      tick();
      n++;
    end
    check({name, "_idle_timeout"}, n < 400, 1);
  endtask

  initial begin
    vecs[0] = '{8'h07, 16'hBEEF, 1'b1};
    vecs[1] = '{8'h01, 16'h1111, 1'b0};
    vecs[2] = '{8'h00, 16'hAAAA, 1'b1};
    vecs[3] = '{8'h02, 16'h2222, 1'b0};
    vecs[4] = '{8'h03, 16'h3333, 1'b0};
    vecs[5] = '{8'h05, 16'h5555, 1'b1};
    vecs[6] = '{8'h04, 16'h4444, 1'b0};
    vecs[7] = '{8'hFF, 16'h9999, 1'b1};
    for (int i = 0; i < 4; i++) sh[i] = 16'h0000;

    reset = 1'b1; cmd_valid = 1'b0; sync_all = 1'b0; f_full = 1'b0;
    cmd_id = 8'h00; cmd_value = 16'h0000;
    repeat (3) tick();
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_write_en", fifo_write_en, 0);
    check("rst_write_data", fifo_write_data, 0);
    check("rst_cmd_error", cmd_error, 0);
    check("rst_busy", busy, 0);
    check("rst_bytes", bytes_written, 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", cmd_ready, 1);
    tick();

    // Single frame: three back-to-back writes, ready low for four cycles.
    push_frame(8'h01, 16'h0123);
    sh[0] = 16'h0123;
    send_cmd(8'h01, 16'h0123);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("frame1_consecutive_we", fifo_write_en, 1);
    end
    @(negedge clk);
    check("frame1_ready_in_next", cmd_ready, 0);
    @(negedge clk);
    check("frame1_ready_back", cmd_ready, 1);
    check("frame1_bytes", bytes_written, 3);
    tick();

    // FIFO-full stall after the ID byte.
    push_frame(8'h04, 16'h00F0);
    sh[3] = 16'h00F0;
    send_cmd(8'h04, 16'h00F0);
    @(negedge clk);
    check("stall_first_we", fifo_write_en, 1);
    tick();
    f_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_no_we", fifo_write_en, 0);
      check("stall_busy", busy, 1);
    end
    tick();
    f_full = 1'b0;
    wait_idle("stall");
    check("stall_bytes", bytes_written, 32'(exp_bytes));

    // Table of commands: invalid ids pulse cmd_error and write nothing.
    for (int v = 0; v < 8; v++) begin
      if (!vecs[v].exp_err) begin
        push_frame(vecs[v].id, vecs[v].val);
        sh[vecs[v].id - 8'd1] = vecs[v].val;
      end
      send_cmd(vecs[v].id, vecs[v].val);
      @(negedge clk);
      check("tbl_cmd_error", cmd_error, 32'(vecs[v].exp_err));
      if (vecs[v].exp_err) begin
        check("tbl_err_no_we", fifo_write_en, 0);
        check("tbl_err_ready", cmd_ready, 1);
        @(negedge clk);
        check("tbl_err_pulse_end", cmd_error, 0);
      end
      tick();
      wait_idle("tbl");
      check("tbl_bytes", bytes_written, 32'(exp_bytes));
    end

    // sync_all replays all four shadows.
    push_replay();
    sync_all = 1'b1;
    tick();
    sync_all = 1'b0;
    check("sync_busy", busy, 1);
    wait_idle("sync");
    check("sync_bytes", bytes_written, 32'(exp_bytes));

    // sync_all and a command in the same cycle: replay goes first.
    begin
      int w0;
      int n = 0;
      push_replay();
      sync_all  = 1'b1;
      cmd_valid = 1'b1;
      cmd_id    = 8'h02;
      cmd_value = 16'h7777;
      #1;
      check("race_ready_blocked", cmd_ready, 0);
      tick();
      sync_all = 1'b0;
      w0 = wr_seen;
      @(negedge clk);
      while (!cmd_ready && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("race_wait_timeout", n < 200, 1);
      check("race_replay_first", wr_seen - w0, 12);
      push_frame(8'h02, 16'h7777);
      sh[1] = 16'h7777;
      tick();
      cmd_valid = 1'b0;
      wait_idle("race");
      check("race_bytes", bytes_written, 32'(exp_bytes));
    end

    // Reset after the first byte of a frame.
    exp_q.push_back(8'h03);
    send_cmd(8'h03, 16'hABCD);
    @(negedge clk);
    check("rstmid_first_we", fifo_write_en, 1);
    tick();
    reset = 1'b1;
    tick();
    check("rstmid_we", fifo_write_en, 0);
    check("rstmid_data", fifo_write_data, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_bytes", bytes_written, 0);
    check("rstmid_err", cmd_error, 0);
    check("rstmid_ready", cmd_ready, 0);
    check("rstmid_queue", exp_q.size(), 0);
    reset = 1'b0;
    exp_bytes = 16'd0;
    for (int i = 0; i < 4; i++) sh[i] = 16'h0000;
    @(negedge clk);
    check("rstmid_ready_back", cmd_ready, 1);
    tick();
    push_frame(8'h01, 16'h0F0F);
    sh[0] = 16'h0F0F;
    send_cmd(8'h01, 16'h0F0F);
    wait_idle("rstmid_frame");
    check("rstmid_frame_bytes", bytes_written, 3);
    push_replay();
    sync_all = 1'b1;
    tick();
    sync_all = 1'b0;
    wait_idle("rstmid_sync");
    check("rstmid_sync_bytes", bytes_written, 15);

    repeat (3) tick();
    check("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
